// File: rtl/rv_pkg.sv
// Shared constants for the RV32IM pipeline.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: claim/release tracking, sticky protocol error, busy summary.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREGS = rv_pkg::NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  input  logic             lw_en,
  input  logic [AW-1:0]    lw_addr,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  output logic [NREGS-1:0] busy,
  output logic             busy_any,
  output logic             err
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             claim_v, lw_v, wb_v;

  assign claim_v = claim_en && (claim_addr != AW'(REG_ZERO));
  assign lw_v    = lw_en && (lw_addr != AW'(REG_ZERO));
  assign wb_v    = wb_en && (wb_addr != AW'(REG_ZERO));

  always_comb begin
    busy_d = busy_q;
    if (lw_v) busy_d[lw_addr] = 1'b0;
    // Claim applied last so back-to-back ops to one destination stay busy.
    if (claim_v) busy_d[claim_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (claim_v && busy_q[claim_addr] && !(lw_v && (lw_addr == claim_addr))) err_d = 1'b1;
    if (lw_v && !busy_q[lw_addr]) err_d = 1'b1;
    if (wb_v && busy_q[wb_addr]) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy     = busy_q;
  assign busy_any = |busy_q;
  assign err      = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with pipeline and long-latency write ports, write-to-read
// bypass and a busy scoreboard.
module reg_file_sb
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned NREGS = rv_pkg::NREGS,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  lw_en,
  input  logic [AW-1:0]         lw_addr,
  input  logic [XLEN-1:0]       lw_data,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_addr,
  output logic                  busy_any,
  output logic                  err,
  output logic [NREGS*XLEN-1:0] regs_flat
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  rf_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .claim_en  (claim_en),
    .claim_addr(claim_addr),
    .lw_en     (lw_en),
    .lw_addr   (lw_addr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .busy      (busy),
    .busy_any  (busy_any),
    .err       (err)
  );

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (wb_en && (wb_addr != AW'(REG_ZERO))) regs_q[wb_addr] <= wb_data;
      if (lw_en && (lw_addr != AW'(REG_ZERO))) regs_q[lw_addr] <= lw_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero, lw_hit, wb_hit;

    assign addr    = rd_addr[k*AW +: AW];
    assign is_zero = (addr == AW'(REG_ZERO));
    assign lw_hit  = lw_en && (lw_addr == addr);
    assign wb_hit  = wb_en && (wb_addr == addr);

    assign rd_data[k*XLEN +: XLEN] = is_zero ? '0      :
                                     lw_hit  ? lw_data :
                                     wb_hit  ? wb_data : regs_q[addr];
    // A result arriving this cycle is forwarded, so the operand is already usable.
    assign rd_busy[k] = !is_zero && busy[addr] && !lw_hit;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign regs_flat[i*XLEN +: XLEN] = regs_q[i];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb: expectations queued at drive time, popped at sample.
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wb_en, lw_en, claim_en;
  logic [AW-1:0]         wb_addr, lw_addr, claim_addr;
  logic [XLEN-1:0]       wb_data, lw_data;
  logic                  busy_any, err;
  logic [NREGS*XLEN-1:0] regs_flat;

  reg_file_sb #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .lw_en     (lw_en),
    .lw_addr   (lw_addr),
    .lw_data   (lw_data),
    .claim_en  (claim_en),
    .claim_addr(claim_addr),
    .busy_any  (busy_any),
    .err       (err),
    .regs_flat (regs_flat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %0h want <nothing>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] rdd(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] regv(input int i);
    return regs_flat[i*XLEN +: XLEN];
  endfunction

  task automatic idle();
    wb_en = 0; wb_addr = '0; wb_data = '0;
    lw_en = 0; lw_addr = '0; lw_data = '0;
    claim_en = 0; claim_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Advance one edge; inputs are then driven right after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    #1 rst_n = 0;
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    set_rd('0, '0);
    #22;
    @(negedge clk);
    rst_n = 1;

    // Reset state on every address.
    for (int a = 0; a < NREGS; a++) begin
      set_rd(AW'(a), AW'(NREGS - 1 - a));
      push("rst_rd0", '0); push("rst_rd1", '0);
      push("rst_busy0", '0); push("rst_busy1", '0);
      #1;
      pop_check(rdd(0)); pop_check(rdd(1));
      pop_check({31'b0, rd_busy[0]}); pop_check({31'b0, rd_busy[1]});
    end
    push("rst_flat", '0); push("rst_busy_any", '0); push("rst_err", '0);
    pop_check({31'b0, |regs_flat}); pop_check({31'b0, busy_any}); pop_check({31'b0, err});

    // Write to register 0 is ignored, even on the bypass path.
    @(negedge clk);
    wb_en = 1; wb_addr = 0; wb_data = 32'hDEADBEEF; set_rd(0, 0);
    push("wr0_bypass", '0);
    #1 pop_check(rdd(0));
    step(); idle();
    push("wr0_stored", '0); push("wr0_err", '0); push("wr0_flat", '0);
    #1;
    pop_check(rdd(0)); pop_check({31'b0, err}); pop_check({31'b0, |regs_flat});

    // Bypass: both ports hit 5, lw wins.
    claim_en = 1; claim_addr = 5;
    step(); idle();
    wb_en = 1; wb_addr = 5; wb_data = 32'h11111111;
    lw_en = 1; lw_addr = 5; lw_data = 32'h22222222;
    set_rd(5, 5);
    push("byp_data", 32'h22222222); push("byp_busy", '0);
    #1 pop_check(rdd(0)); pop_check({31'b0, rd_busy[0]});
    step(); idle();
    push("byp_stored", 32'h22222222); push("byp_busy_next", '0); push("byp_flat5", 32'h22222222);
    #1 pop_check(rdd(0)); pop_check({31'b0, rd_busy[0]}); pop_check(regv(5));

    // Scoreboard claim and release on 7.
    do_reset();
    @(negedge clk);
    claim_en = 1; claim_addr = 7; set_rd(0, 7);
    push("sb_claim_same_cycle", '0);
    #1 pop_check({31'b0, rd_busy[1]});
    step(); idle();
    push("sb_busy7", 1); push("sb_busy_any", 1);
    #1 pop_check({31'b0, rd_busy[1]}); pop_check({31'b0, busy_any});
    for (int i = 0; i < 4; i++) step();
    lw_en = 1; lw_addr = 7; lw_data = 32'h0000002A;
    push("sb_lw_busy", '0); push("sb_lw_data", 32'h2A); push("sb_lw_any_still", 1);
    #1 pop_check({31'b0, rd_busy[1]}); pop_check(rdd(1)); pop_check({31'b0, busy_any});
    step(); idle();
    push("sb_any_clear", '0); push("sb_err", '0); push("sb_stored7", 32'h2A);
    #1 pop_check({31'b0, busy_any}); pop_check({31'b0, err}); pop_check(rdd(1));

    // Claim and release of 9 in the same cycle keeps it busy.
    do_reset();
    @(negedge clk);
    claim_en = 1; claim_addr = 9;
    step(); idle();
    claim_en = 1; claim_addr = 9; lw_en = 1; lw_addr = 9; lw_data = 32'h99; set_rd(9, 0);
    push("cr_masked", '0);
    #1 pop_check({31'b0, rd_busy[0]});
    step(); idle();
    push("cr_busy", 1); push("cr_err", '0); push("cr_data", 32'h99);
    #1 pop_check({31'b0, rd_busy[0]}); pop_check({31'b0, err}); pop_check(rdd(0));
    lw_en = 1; lw_addr = 9; lw_data = 32'h100;
    step(); idle();
    push("cr_release", '0); push("cr_any", '0); push("cr_err2", '0);
    #1 pop_check({31'b0, rd_busy[0]}); pop_check({31'b0, busy_any}); pop_check({31'b0, err});

    // Error: unclaimed lw to 3; the write still happens.
    do_reset();
    @(negedge clk);
    lw_en = 1; lw_addr = 3; lw_data = 32'h33;
    push("e_lw_pre", '0);
    #1 pop_check({31'b0, err});
    step(); idle();
    push("e_lw", 1); push("e_lw_written", 32'h33);
    #1 pop_check({31'b0, err}); pop_check(regv(3));
    step(); step();
    push("e_lw_sticky", 1);
    #1 pop_check({31'b0, err});
    do_reset();
    push("e_lw_reset", '0);
    #1 pop_check({31'b0, err});

    // Error: double claim of 4.
    @(negedge clk);
    claim_en = 1; claim_addr = 4;
    step();
    push("e_dc_first", '0);
    #1 pop_check({31'b0, err});
    step(); idle();
    push("e_dc", 1);
    #1 pop_check({31'b0, err});
    step(); step();
    push("e_dc_sticky", 1);
    #1 pop_check({31'b0, err});

    // Error: wb to busy 6.
    do_reset();
    @(negedge clk);
    claim_en = 1; claim_addr = 6;
    step(); idle();
    wb_en = 1; wb_addr = 6; wb_data = 32'h66;
    step(); idle();
    push("e_waw", 1); push("e_waw_written", 32'h66);
    #1 pop_check({31'b0, err}); pop_check(regv(6));
    step(); step();
    push("e_waw_sticky", 1);
    #1 pop_check({31'b0, err});

    // Async reset between edges.
    do_reset();
    @(negedge clk);
    claim_en = 1; claim_addr = 12;
    step(); idle();
    wb_en = 1; wb_addr = 13; wb_data = 32'h5A5A5A5A;
    step(); idle();
    push("ar_pre13", 32'h5A5A5A5A); push("ar_pre_any", 1);
    #1 pop_check(regv(13)); pop_check({31'b0, busy_any});
    rst_n = 0;
    push("ar_flat", '0); push("ar_any", '0); push("ar_err", '0);
    #1 pop_check({31'b0, |regs_flat}); pop_check({31'b0, busy_any}); pop_check({31'b0, err});
    rst_n = 1;
    lw_en = 1; lw_addr = 12; lw_data = 32'h12;
    step(); idle();
    push("ar_late_lw", 1);
    #1 pop_check({31'b0, err});

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: got %0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised, multi-read-port integer register file with two write ports and a per-register busy scoreboard, for the RV32IM pipeline. Port 0 carries the normal in-order WB-stage writeback. Port 1 carries results from long-latency units such as the iterative divider. Decode marks a destination busy with a claim when it issues a long-latency op. The file exposes busy status per read port so the hazard unit can stall, and it provides same-cycle write-to-read bypass.

## Interface
- `XLEN`, 32, register width in bits.
- `NREGS`, 32, number of registers; a power of two, at least 2; register 0 is hard-wired zero.
- `NRD`, 2, number of read ports, from 1 to 4.
- `AW`, `$clog2(NREGS)`, address width; derived, not overridable.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rd_addr` input NRD*AW: flattened read addresses; port k is `rd_addr[k*AW +: AW]`.
- `rd_data` output NRD*XLEN: flattened read data; port k is `rd_data[k*XLEN +: XLEN]`.
- `rd_busy` output NRD: the addressed register has a result still outstanding.
- `wb_en`, `wb_addr`, `wb_data` input 1/AW/XLEN: write port 0, the pipeline writeback.
- `lw_en`, `lw_addr`, `lw_data` input 1/AW/XLEN: write port 1, the long-latency writeback.
- `claim_en`, `claim_addr` input 1/AW: mark a destination register busy.
- `busy_any` output 1: OR of all busy bits.
- `err` output 1: sticky protocol-violation flag.
- `regs_flat` output NREGS*XLEN: all registers flattened for debug; register i is `regs_flat[i*XLEN +: XLEN]`.

## Operation
- **Reset.**
  - Every register is 0, every busy bit is 0, and `err` is 0.
  - Consequently `rd_data`, `rd_busy`, `busy_any` and `regs_flat` all read 0.
- **Register 0.**
  - Writes and claims to address 0 are ignored.
  - Reads of address 0 return 0 with `rd_busy` 0.
  - Register 0 never sets `err`.
- **Writes.**
  - Each enabled port writes its data on the rising edge.
  - If both ports target the same nonzero address, port 1 (`lw`) wins.
- **Scoreboard.**
  - A claim sets the busy bit of `claim_addr`.
  - An `lw` write clears the busy bit of `lw_addr`.
  - A claim and an `lw` to the same address in the same cycle leave the bit set (the claim wins), which supports back-to-back divides to the same destination.
  - `wb` writes never change the scoreboard.
- **Read path**, per read port, is combinational, in this priority:
  - Address 0 returns 0.
  - Otherwise, if `lw_en` targets the address, return `lw_data`.
  - Otherwise, if `wb_en` targets the address, return `wb_data`.
  - Otherwise return the stored value.
- **Busy on the read path.**
  - `rd_busy` is the registered busy bit, masked to 0 when `lw_en` targets the same address in that cycle; the forwarded result makes the operand usable immediately.
  - A claim in the current cycle is not visible on `rd_busy` until the next cycle.
- **Error conditions.** `err` is set on the next edge by any of the following, each for a nonzero address:
  - A claim to a register that is already busy, unless `lw` releases it in the same cycle.
  - An `lw` write to a register that is not busy.
  - A `wb` write to a busy register (a WAW violation); port 1 precedence still applies.
- **Error persistence.** `err` is cleared only by reset. An error never blocks a write.

## Timing
- Read latency is 0 cycles, combinational from `rd_addr` and the write ports.
- Write-to-storage latency is 1 edge.
- Claim-to-`rd_busy` latency is 1 edge.
- `busy_any` is a pure function of the registered busy bits.
- When `rst_n` is asserted mid-operation, all state clears immediately. A long-latency result still in flight is dropped by its producer, which must also be reset; `lw` writes arriving after reset set `err`.
- `regs_flat` reflects stored state only, with no bypass.

## Structure
- The shared package `rv_pkg` holds the `XLEN` default, the `NREGS` default, and the constant `REG_ZERO = 0`.
- One sub-module, `rf_scoreboard`, holds the busy vector, the claim/release logic, `err` detection and `busy_any`.
- Storage, write muxing and bypass stay in the top level.

## Test plan
- **Reset and write 0.**
  - Apply reset, then read all addresses: `rd_data` is 0 and `rd_busy` is 0.
  - Issue `wb_en` with addr 0, data `0xDEADBEEF`: address 0 still reads 0 and `err` stays 0.
- **Bypass.**
  - In the same cycle, drive `wb` addr 5 = `0x11111111` and `lw` addr 5 = `0x22222222` (with 5 previously claimed).
  - Port 0 reading 5 returns `0x22222222` that cycle.
  - Next cycle the stored value is `0x22222222` and `rd_busy` is 0.
- **Scoreboard.**
  - Claim 7, then next cycle read 7: `rd_busy=1`, `busy_any=1`.
  - Four cycles later issue `lw` 7 = `0x0000002A`: the same cycle gives `rd_busy=0` and `rd_data=0x2A`; the next cycle gives `busy_any=0`.
- **Claim and release together.**
  - Claim 9 and, one cycle later, `lw` 9 together with claim 9.
  - Busy stays 1 and `err` stays 0.
  - A subsequent `lw` 9 clears busy.
- **Errors.** Each case is run from reset and checked separately:
  - Unclaimed `lw` to 3 gives `err=1` next cycle.
  - Double claim of 4 gives `err=1`.
  - `wb` to a busy 6 gives `err=1`.
  - In every case `err` holds until `rst_n` is asserted.
- **Async reset mid-flight.**
  - Claim 12, write `wb` 13 = `0x5A5A5A5A`, then pulse `rst_n` low between edges.
  - Outputs clear without a clock edge: `regs_flat` is 0 and `busy_any` is 0.
